// File: rtl/colorbar_fifo_src.sv
// rtl/colorbar_fifo_src.sv - RGB565 8-bar colour frame source for the async pixel FIFO write port
// Optional feature: define COLORBAR_SCROLL_EN to shift the bars by one position per completed frame.
module colorbar_fifo_src #(
    parameter int DATASIZE   = 16,
    parameter int H_ACTIVE   = 480,
    parameter int V_ACTIVE   = 800,
    parameter int GAP_CYCLES = 16
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                enable,
    input  logic                afull,
    input  logic                full,
    output logic [DATASIZE-1:0] wdata,
    output logic                wen,
    output logic                sof,
    output logic                eol,
    output logic                eof,
    output logic [7:0]          frame_cnt,
    output logic                busy
);

    localparam logic [11:0] X_LAST   = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST   = 12'(V_ACTIVE - 1);
    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t      state, state_nxt;
    logic [11:0] x, x_nxt, y, y_nxt, bar_cnt, bar_cnt_nxt;
    logic [2:0]  bar_idx, bar_idx_nxt, start_idx;
    logic [7:0]  gap_cnt, gap_cnt_nxt, frame_cnt_nxt;
    logic [15:0] colour;

`ifdef COLORBAR_SCROLL_EN
    assign start_idx = frame_cnt[2:0];
`else
    assign start_idx = 3'd0;
`endif

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            bar_cnt   <= '0;
            bar_idx   <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            x         <= x_nxt;
            y         <= y_nxt;
            bar_cnt   <= bar_cnt_nxt;
            bar_idx   <= bar_idx_nxt;
            gap_cnt   <= gap_cnt_nxt;
            frame_cnt <= frame_cnt_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        colour = 16'h0000;
        case (bar_idx)
            3'd0: colour = 16'hFFFF;
            3'd1: colour = 16'hFFE0;
            3'd2: colour = 16'h07FF;
            3'd3: colour = 16'h07E0;
            3'd4: colour = 16'hF81F;
            3'd5: colour = 16'hF800;
            3'd6: colour = 16'h001F;
            default: colour = 16'h0000;
        endcase
    end

    // Write strobe and markers are combinational so back-pressure stalls with zero latency.
    assign wen   = (state == ACTIVE) && !afull && !full;
    assign wdata = wen ? DATASIZE'(colour) : '0;
    assign sof   = wen && (x == 12'd0) && (y == 12'd0);
    assign eol   = wen && (x == X_LAST);
    assign eof   = eol && (y == Y_LAST);

    always_comb begin
        state_nxt     = state;
        x_nxt         = x;
        y_nxt         = y;
        bar_cnt_nxt   = bar_cnt;
        bar_idx_nxt   = bar_idx;
        gap_cnt_nxt   = gap_cnt;
        frame_cnt_nxt = frame_cnt;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt   = ACTIVE;
                    x_nxt       = '0;
                    y_nxt       = '0;
                    bar_cnt_nxt = '0;
                    bar_idx_nxt = start_idx;
                end
            end
            ACTIVE: begin
                if (wen) begin
                    if (eol) begin
                        x_nxt       = '0;
                        bar_cnt_nxt = '0;
                        bar_idx_nxt = start_idx;
                        if (eof) begin
                            y_nxt         = '0;
                            gap_cnt_nxt   = '0;
                            frame_cnt_nxt = frame_cnt + 8'd1;
                            state_nxt     = GAP;
                        end else begin
                            y_nxt = y + 12'd1;
                        end
                    end else begin
                        x_nxt = x + 12'd1;
                        if (bar_cnt == BAR_LAST) begin
                            bar_cnt_nxt = '0;
                            bar_idx_nxt = bar_idx + 3'd1;
                        end else begin
                            bar_cnt_nxt = bar_cnt + 12'd1;
                        end
                    end
                end
            end
            GAP: begin
                gap_cnt_nxt = gap_cnt + 8'd1;
                // start_idx here already sees the incremented frame_cnt.
                if (gap_cnt == GAP_LAST) begin
                    state_nxt   = enable ? ACTIVE : IDLE;
                    x_nxt       = '0;
                    y_nxt       = '0;
                    bar_cnt_nxt = '0;
                    bar_idx_nxt = start_idx;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_colorbar_fifo_src.sv
// tb/tb_colorbar_fifo_src.sv - directed self-checking bench for colorbar_fifo_src (16x2 frames, 4-clock gap)
module tb_colorbar_fifo_src;

    localparam int H = 16;
    localparam int V = 2;
    localparam int G = 4;

    logic        wclk = 1'b0;
    logic        wrst_n, enable, afull, full;
    logic [15:0] wdata;
    logic        wen, sof, eol, eof, busy;
    logic [7:0]  frame_cnt;

    int errors = 0;
    int checks = 0;

    logic [15:0] cols [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    colorbar_fifo_src #(.DATASIZE(16), .H_ACTIVE(H), .V_ACTIVE(V), .GAP_CYCLES(G)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .enable(enable), .afull(afull), .full(full),
        .wdata(wdata), .wen(wen), .sof(sof), .eol(eol), .eof(eof),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_col(input int fr, input int p);
        int s;
`ifdef COLORBAR_SCROLL_EN
        s = fr % 8;
`else
        s = 0;
`endif
        return cols[((p % H) / 2 + s) % 8];
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    // Waits for the next write (at most maxw idle clocks), checks it, returns after it commits.
    task automatic next_write(input int fr, input int p, input int maxw);
        int n = 0;
        @(negedge wclk);
        while (!wen && n < 64) begin
            @(negedge wclk);
            n++;
        end
        check($sformatf("wait f%0d p%0d", fr, p), 32'(n <= maxw), 32'd1);
        check($sformatf("wdata f%0d p%0d", fr, p), {16'h0, wdata}, {16'h0, exp_col(fr, p)});
        check($sformatf("sof f%0d p%0d", fr, p), {31'd0, sof}, 32'(p == 0));
        check($sformatf("eol f%0d p%0d", fr, p), {31'd0, eol}, 32'((p % H) == H - 1));
        check($sformatf("eof f%0d p%0d", fr, p), {31'd0, eof}, 32'(p == H * V - 1));
        tick();
    endtask

    task automatic idle_clocks(input string tag, input int n, input logic exp_busy);
        for (int i = 0; i < n; i++) begin
            @(negedge wclk);
            check($sformatf("%s wen %0d", tag, i), {31'd0, wen}, 32'd0);
            check($sformatf("%s wdata %0d", tag, i), {16'h0, wdata}, 32'd0);
            check($sformatf("%s busy %0d", tag, i), {31'd0, busy}, {31'd0, exp_busy});
            tick();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        wrst_n = 1'b0; enable = 1'b0; afull = 1'b0; full = 1'b0;
        tick(); tick();
        @(negedge wclk);
        check("rst wen", {31'd0, wen}, 32'd0);
        check("rst sof/eol/eof", {29'd0, sof, eol, eof}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("rst wdata", {16'h0, wdata}, 32'd0);
        tick();
        wrst_n = 1'b1; enable = 1'b1;

        // Frame 0: free-running, then exact gap length.
        for (int p = 0; p < H * V; p++) next_write(0, p, (p == 0) ? 1 : 0);
        check("f0 frame_cnt", {24'd0, frame_cnt}, 32'd1);
        idle_clocks("gap0", G, 1'b1);

        // Frame 1: afull stall at pixel 7, full stall at pixel 20.
        for (int p = 0; p < 7; p++) next_write(1, p, 0);
        afull = 1'b1;
        idle_clocks("afull", 5, 1'b1);
        afull = 1'b0;
        for (int p = 7; p < 20; p++) next_write(1, p, 0);
        full = 1'b1;
        idle_clocks("full", 3, 1'b1);
        full = 1'b0;
        for (int p = 20; p < H * V; p++) next_write(1, p, 0);
        check("f1 frame_cnt", {24'd0, frame_cnt}, 32'd2);
        idle_clocks("gap1", G, 1'b1);

        // Frame 2: enable dropped at write 10; frame and gap still complete.
        for (int p = 0; p <= 10; p++) next_write(2, p, 0);
        enable = 1'b0;
        for (int p = 11; p < H * V; p++) next_write(2, p, 0);
        check("f2 frame_cnt", {24'd0, frame_cnt}, 32'd3);
        idle_clocks("gap2", G, 1'b1);
        idle_clocks("idle", 10, 1'b0);

        // Frame 3 aborted by a one-clock reset after write 19.
        enable = 1'b1;
        for (int p = 0; p < 20; p++) next_write(3, p, (p == 0) ? 1 : 0);
        wrst_n = 1'b0;
        tick();
        wrst_n = 1'b1;
        @(negedge wclk);
        check("post-rst wen", {31'd0, wen}, 32'd0);
        check("post-rst frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("post-rst busy", {31'd0, busy}, 32'd0);
        tick();

        // Nine frames from reset: first pixel tracks the scroll setting.
        for (int f = 0; f < 9; f++) begin
            for (int p = 0; p < H * V; p++)
                next_write(f, p, (p != 0) ? 0 : (f == 0) ? 0 : G);
            check($sformatf("scroll frame_cnt %0d", f), {24'd0, frame_cnt}, 32'(f + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
